// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use and branch-operand stalls,
// multi-cycle divider scheduling with HI/LO write strobe, and flush control.
module hazard_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_UseRs,
    input  logic       ID_UseRt,
    input  logic       ID_Branch,
    input  logic       ID_EX_MemRead,
    input  logic       ID_EX_RegWrite,
    input  logic [4:0] ID_EX_waddr,
    input  logic       EX_MEM_MemRead,
    input  logic [4:0] EX_MEM_waddr,
    input  logic       EX_Div,
    input  logic       BranchTaken,
    input  logic       ExcFlush,
    output logic       PC_Write,
    output logic       IF_ID_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Write,
    output logic       ID_EX_Flush,
    output logic       EX_MEM_Flush,
    output logic       div_start,
    output logic       hilo_we,
    output logic       div_busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic ex_match, mem_match, load_use, branch_hz, hazard, freeze;

    // Operand compares against EX/MEM destinations; $0 never matches.
    always_comb begin
        ex_match  = (ID_EX_waddr != 5'd0) &&
                    ((ID_UseRs && (ID_rs == ID_EX_waddr)) ||
                     (ID_UseRt && (ID_rt == ID_EX_waddr)));
        mem_match = (EX_MEM_waddr != 5'd0) &&
                    ((ID_UseRs && (ID_rs == EX_MEM_waddr)) ||
                     (ID_UseRt && (ID_rt == EX_MEM_waddr)));
        load_use  = ID_EX_MemRead && ex_match;
        // Branches compare in ID, so an EX ALU result or a MEM load is too late.
        branch_hz = ID_Branch && ((ID_EX_RegWrite && ex_match) ||
                                  (EX_MEM_MemRead && mem_match));
        hazard    = load_use || branch_hz;
    end

    // Divider state and iteration counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic and prioritised pipeline control outputs.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = '0;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Write  = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        div_start    = 1'b0;
        hilo_we      = 1'b0;
        div_busy     = (state != IDLE);

        unique case (state)
            IDLE: begin
                if (EX_Div && !ExcFlush) begin
                    state_nxt = BUSY;
                    div_start = 1'b1;
                end
            end
            BUSY: begin
                cnt_nxt = cnt + CNT_ONE;
                if (ExcFlush) begin
                    state_nxt = IDLE;      // divide aborted, no result written
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end
            end
            DONE: begin
                // The div leaves EX this cycle; an EX_Div here is the same one.
                state_nxt = IDLE;
                hilo_we   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        // The start cycle also freezes so the div is still in EX when BUSY begins.
        freeze = (state == BUSY) || div_start;

        if (ExcFlush) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
        end else if (freeze) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Flush = 1'b1;
        end else if (hazard) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Flush  = 1'b1;
        end else if (BranchTaken) begin
            IF_ID_Flush  = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hazards, divider sequencing, flush and reset.
module tb_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] ID_rs, ID_rt, ID_EX_waddr, EX_MEM_waddr;
    logic       ID_UseRs, ID_UseRt, ID_Branch, ID_EX_MemRead, ID_EX_RegWrite;
    logic       EX_MEM_MemRead, EX_Div, BranchTaken, ExcFlush;
    logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush;
    logic       EX_MEM_Flush, div_start, hilo_we, div_busy;

    int n_cmp = 0;
    int n_bad = 0;

    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
    //  EX_MEM_Flush, div_start, hilo_we, div_busy}
    localparam logic [8:0] NORM    = 9'b110100000;
    localparam logic [8:0] STALL   = 9'b000110000;
    localparam logic [8:0] BRFLUSH = 9'b111100000;
    localparam logic [8:0] START   = 9'b000001100;
    localparam logic [8:0] BUSYV   = 9'b000001001;
    localparam logic [8:0] DONEV   = 9'b110100011;
    localparam logic [8:0] EXC_B   = 9'b111111001;
    localparam logic [8:0] EXC_D   = 9'b111111011;

    wire [8:0] outs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
                       EX_MEM_Flush, div_start, hilo_we, div_busy};

    hazard_ctrl dut (
        .clock(clock), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
        .ID_Branch(ID_Branch), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_waddr(ID_EX_waddr),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_waddr(EX_MEM_waddr),
        .EX_Div(EX_Div), .BranchTaken(BranchTaken), .ExcFlush(ExcFlush),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush),
        .EX_MEM_Flush(EX_MEM_Flush), .div_start(div_start), .hilo_we(hilo_we),
        .div_busy(div_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        ID_rs = 0; ID_rt = 0; ID_UseRs = 0; ID_UseRt = 0; ID_Branch = 0;
        ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_waddr = 0;
        EX_MEM_MemRead = 0; EX_MEM_waddr = 0;
        EX_Div = 0; BranchTaken = 0; ExcFlush = 0;
    endtask

    // Full divide with EX_Div held through DONE; checks every cycle.
    task automatic run_div(input string tag);
        EX_Div = 1;
        #1 chk({tag, "_start"}, outs, START);
        tick();
        for (int i = 0; i < 32; i++) begin
            #1 chk({tag, "_busy"}, outs, BUSYV);
            tick();
        end
        #1 chk({tag, "_done"}, outs, DONEV);
        tick();
    endtask

    initial begin
        clr();
        reset = 0;
        #1 chk("reset_outs", outs, NORM);
        #12 reset = 1;
        tick();
        #1 chk("idle_outs", outs, NORM);

        // lw $3 in EX, add uses rs=3: one stall, then load in MEM -> normal
        ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_waddr = 3; ID_rs = 3; ID_UseRs = 1;
        #1 chk("lu_stall", outs, STALL);
        tick();
        ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_waddr = 0;
        EX_MEM_MemRead = 1; EX_MEM_waddr = 3;
        #1 chk("lu_after", outs, NORM);
        tick(); clr();

        // $0 destination never stalls
        ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_waddr = 0; ID_rs = 0; ID_UseRs = 1;
        #1 chk("lu_r0", outs, NORM);
        // register matches but the field is not read
        ID_EX_waddr = 7; ID_rt = 7; ID_UseRs = 0; ID_UseRt = 0;
        #1 chk("lu_unused", outs, NORM);
        ID_UseRt = 1;
        #1 chk("lu_rt", outs, STALL);
        tick(); clr();

        // lw $4 then beq rs=4: two stall cycles
        ID_Branch = 1; ID_rs = 4; ID_UseRs = 1;
        ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_waddr = 4;
        #1 chk("br_ld_1", outs, STALL);
        tick();
        ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_waddr = 0;
        EX_MEM_MemRead = 1; EX_MEM_waddr = 4;
        #1 chk("br_ld_2", outs, STALL);
        tick();
        EX_MEM_MemRead = 0; EX_MEM_waddr = 0;
        #1 chk("br_ld_3", outs, NORM);
        tick(); clr();

        // addu $4 then beq rt=4: one stall cycle; taken is ignored while stalled
        ID_Branch = 1; ID_rt = 4; ID_UseRt = 1; BranchTaken = 1;
        ID_EX_RegWrite = 1; ID_EX_waddr = 4;
        #1 chk("br_alu_1", outs, STALL);
        tick();
        ID_EX_RegWrite = 0; ID_EX_waddr = 0; EX_MEM_waddr = 4;
        #1 chk("br_alu_taken", outs, BRFLUSH);
        tick(); clr();

        // single divide
        run_div("div1");
        EX_Div = 0;
        #1 chk("div1_idle", outs, NORM);
        tick();

        // two adjacent divides: second starts right after DONE
        run_div("b2b_a");
        run_div("b2b_b");
        EX_Div = 0;
        #1 chk("b2b_idle", outs, NORM);
        tick();

        // exception at BUSY cnt=10 aborts the divide
        EX_Div = 1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        ExcFlush = 1;
        #1 chk("exc_busy", outs, EXC_B);
        tick();
        ExcFlush = 0; EX_Div = 0;
        #1 chk("exc_after", outs, NORM);
        tick();
        #1 chk("exc_no_hilo", outs, NORM);

        // exception in DONE still writes HI/LO
        EX_Div = 1;
        tick();
        for (int i = 0; i < 32; i++) tick();
        ExcFlush = 1;
        #1 chk("exc_done", outs, EXC_D);
        tick();
        ExcFlush = 0; EX_Div = 0;
        #1 chk("exc_done_after", outs, NORM);
        tick();

        // reset at BUSY cnt=5, then a full divide afterwards
        EX_Div = 1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        #1 chk("rst_pre", outs, BUSYV);
        reset = 0;
        #1 chk("rst_mid_busy", outs, START);
        EX_Div = 0;
        #1 chk("rst_idle", outs, NORM);
        tick();
        reset = 1;
        tick();
        run_div("div_post_rst");
        EX_Div = 0;
        #1 chk("post_rst_idle", outs, NORM);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage core; works alongside the operand-forwarding unit.
- Detects hazards that forwarding cannot resolve (load-use, branch-in-ID operand not ready) and inserts stalls or bubbles.
- Schedules the multi-cycle divider: freezes the pipeline while it runs and owns the HI/LO write strobe.
- Flushes on taken branch or exception; an exception aborts an in-flight divide.

Parameters:
- DIV_CYCLES, 32, number of divider iterations after start; must be >= 2.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ID_rs  input  5  rs field of the instruction in ID.
- ID_rt  input  5  rt field of the instruction in ID.
- ID_UseRs  input  1  ID instruction reads rs.
- ID_UseRt  input  1  ID instruction reads rt.
- ID_Branch  input  1  ID instruction resolves a branch/jr/jalr in ID.
- ID_EX_MemRead  input  1  EX-stage instruction is a load.
- ID_EX_RegWrite  input  1  EX-stage instruction writes the GPR file.
- ID_EX_waddr  input  5  EX-stage destination register.
- EX_MEM_MemRead  input  1  MEM-stage instruction is a load.
- EX_MEM_waddr  input  5  MEM-stage destination register.
- EX_Div  input  1  div/divu in EX.
- BranchTaken  input  1  branch in ID resolved taken.
- ExcFlush  input  1  exception/eret flush request.
- PC_Write  output  1  PC update enable.
- IF_ID_Write  output  1  IF/ID register enable.
- IF_ID_Flush  output  1  IF/ID register clear.
- ID_EX_Write  output  1  ID/EX register enable.
- ID_EX_Flush  output  1  insert bubble into ID/EX.
- EX_MEM_Flush  output  1  insert bubble into EX/MEM.
- div_start  output  1  one-cycle start pulse to the divider.
- hilo_we  output  1  HI/LO write strobe for the divider result.
- div_busy  output  1  divider FSM not IDLE.

Behaviour:
- Registered state: FSM {IDLE, BUSY, DONE}, cnt[CNT_W-1:0]. On reset: IDLE and cnt=0.
- In IDLE with no hazard, outputs are PC_Write=1, IF_ID_Write=1, ID_EX_Write=1, all flushes 0, div_start=0, hilo_we=0, div_busy=0.
- These are also the reset-time values; all outputs are combinational from state and inputs.
- Register $0 never causes a hazard: every compare also requires waddr != 0.
- Load-use hazard:
  - Condition: ID_EX_MemRead and ((ID_UseRs and ID_rs==ID_EX_waddr) or (ID_UseRt and ID_rt==ID_EX_waddr)).
  - Response: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. This lasts one cycle per occurrence.
- Branch hazard (ID_Branch=1):
  - Stall as for load-use if ID_EX_RegWrite matches rs/rt. This covers an ALU result that is not yet forwardable to ID at compare time.
  - Also stall if EX_MEM_MemRead matches.
  - A load feeding a branch therefore stalls 2 cycles. An ALU op feeding a branch stalls 1 cycle.
- Divider FSM:
  - IDLE→BUSY when EX_Div=1 and ExcFlush=0. div_start=1 in that cycle; cnt←0.
  - BUSY: cnt increments each cycle. PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Flush=1, so the div stays in EX and MEM sees bubbles. div_busy=1.
  - BUSY→DONE when cnt==DIV_CYCLES-1.
  - DONE, for one cycle: hilo_we=1, stalls released, div_busy=1. Next state is IDLE.
  - The div advances out of EX in the DONE cycle. An EX_Div seen in DONE does not restart the FSM, because it is the same instruction.
  - Back-to-back divs: the second div reaches EX one cycle after DONE and starts normally.
- Priority, highest first: ExcFlush > divider BUSY > branch/load-use stall > BranchTaken flush.
- ExcFlush=1:
  - Outputs: IF_ID_Flush=1, ID_EX_Flush=1, EX_MEM_Flush=1, PC_Write=1; all stalls suppressed.
  - If the FSM is in BUSY, it returns to IDLE next cycle with no hilo_we (divide aborted).
  - If the FSM is in DONE, hilo_we still fires, because the div has completed architecturally.
- BranchTaken=1 with no stall: IF_ID_Flush=1. While stalled, BranchTaken is ignored; the branch re-resolves after the stall.
- Asynchronous reset mid-BUSY: immediate IDLE, cnt=0, and no hilo_we.

Test Plan:
- lw $3 in EX, ID add uses rs=3 → exactly 1 cycle of PC_Write=0/IF_ID_Write=0/ID_EX_Flush=1, then normal. Same case with rs=0 → no stall.
- lw $4 in EX, ID beq rs=4 → 2 consecutive stall cycles. addu $4 in EX, ID beq rt=4 → 1 stall cycle.
- div in EX, DIV_CYCLES=32 → div_start pulse in cycle 0; 32 cycles with div_busy=1 and PC_Write=0; hilo_we=1 in cycle 33; PC resumes that cycle.
- Two adjacent divs → two div_start pulses 34 cycles apart and two hilo_we pulses; no extra start is issued in the DONE cycle.
- ExcFlush asserted at BUSY cnt=10 → all three flushes high; next cycle IDLE; hilo_we never asserted.
- Reset (low) at BUSY cnt=5 → div_busy=0 immediately, PC_Write=1; after release, a new div runs the full 34-cycle sequence.
